// File: rtl/gnrl_dpram.sv
// gnrl_dpram: simple dual-port SRAM with one write port and one read port.
// Provides byte-lane write masks, RD_LAT-cycle registered reads with a valid
// strobe, out-of-range detection, and a zero-fill sequence after reset.
// Optional build macro GNRL_DPRAM_FWD_EN: a read and a write accepted in the
// same cycle to the same word return the merged new data (write-first).
// Without it, that read returns the old word (read-first).
module gnrl_dpram #(
    parameter int DP     = 512,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int MW     = (DW + 7) / 8,
    parameter int ASH    = 2,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_din,
    input  logic [MW-1:0] wr_wem,
    output logic          wr_rdy,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_rdy,
    output logic          rd_vld,
    output logic [DW-1:0] rd_dout,
    output logic          rd_err
);

    localparam int IW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] clr_cnt, clr_cnt_nxt;
    logic          clr_we;
    logic          run;

    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_in, rd_in;
    logic          wr_acc, rd_acc;
    logic [IW-1:0] wr_wi, rd_ri;
    logic [DW-1:0] wr_bmask, wr_merged, mem_rd, rd_data;

    logic [DW-1:0] mem [DP];

    logic          s1_vld, s1_err;
    logic [DW-1:0] s1_dout;

    // State and clear-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Clear sequencing: counter walks 0..DP-1 writing zeros, then RUN on the
    // cycle after the last word is cleared
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        run         = 1'b0;
        case (state)
            INIT: begin
                if (clr_cnt == CW'(DP)) begin
                    state_nxt = RUN;
                end else begin
                    clr_we      = 1'b1;
                    clr_cnt_nxt = clr_cnt + CW'(1);
                end
            end
            RUN:     run = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    assign init_done = run;
    assign wr_rdy    = run;
    assign rd_rdy    = run;

    assign wr_idx = wr_addr >> ASH;
    assign rd_idx = rd_addr >> ASH;
    assign wr_in  = (wr_idx < AW'(DP));
    assign rd_in  = (rd_idx < AW'(DP));
    assign wr_acc = wr_req & run & wr_in;
    assign rd_acc = rd_req & run;
    assign wr_wi  = wr_idx[IW-1:0];
    assign rd_ri  = rd_idx[IW-1:0];

    // Expand lane enables to a per-bit mask; the top lane may be partial
    always_comb begin
        wr_bmask = '0;
        for (int unsigned b = 0; b < DW; b++) begin
            wr_bmask[b] = wr_wem[b / 8];
        end
    end

    assign wr_merged = (mem[wr_wi] & ~wr_bmask) | (wr_din & wr_bmask);
    assign mem_rd    = mem[rd_ri];

    // Storage: clear port during INIT, masked write port during RUN
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt[IW-1:0]] <= '0;
        end else if (wr_acc) begin
            mem[wr_wi] <= wr_merged;
        end
    end

    // Read data selection: zero for out-of-range, optional write-first bypass
    always_comb begin
        rd_data = rd_in ? mem_rd : '0;
`ifdef GNRL_DPRAM_FWD_EN
        if (wr_acc && rd_in && (wr_idx == rd_idx)) begin
            rd_data = wr_merged;
        end
`endif
    end

    // First read stage: sample memory at the accept edge; data holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_err  <= 1'b0;
            s1_dout <= '0;
        end else begin
            s1_vld <= rd_acc;
            s1_err <= rd_acc & ~rd_in;
            if (rd_acc) begin
                s1_dout <= rd_data;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_vld, s2_err;
            logic [DW-1:0] s2_dout;

            // Extra output register stage for two-cycle latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld  <= 1'b0;
                    s2_err  <= 1'b0;
                    s2_dout <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    s2_err <= s1_err;
                    if (s1_vld) begin
                        s2_dout <= s1_dout;
                    end
                end
            end

            assign rd_vld  = s2_vld;
            assign rd_err  = s2_err;
            assign rd_dout = s2_dout;
        end else begin : g_lat1
            assign rd_vld  = s1_vld;
            assign rd_err  = s1_err;
            assign rd_dout = s1_dout;
        end
    endgenerate

endmodule

// File: tb/tb_gnrl_dpram.sv
// Testbench for gnrl_dpram: two DP=16/DW=32 instances (RD_LAT=1 and 2) share
// stimulus and are checked every cycle against a word-array reference model;
// a DW=20 instance checks partial top-lane writes.
module tb_gnrl_dpram;

    localparam int DP = 16;
`ifdef GNRL_DPRAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [31:0] wr_addr = '0, rd_addr = '0, wr_din = '0;
    logic [3:0]  wr_wem = '0;

    logic        a_init_done, a_wr_rdy, a_rd_rdy, a_rd_vld, a_rd_err;
    logic [31:0] a_rd_dout;
    logic        b_init_done, b_wr_rdy, b_rd_rdy, b_rd_vld, b_rd_err;
    logic [31:0] b_rd_dout;

    logic        c_wr_req = 1'b0, c_rd_req = 1'b0;
    logic [31:0] c_wr_addr = '0, c_rd_addr = '0;
    logic [19:0] c_wr_din = '0;
    logic [2:0]  c_wr_wem = '0;
    logic        c_init_done, c_wr_rdy, c_rd_rdy, c_rd_vld, c_rd_err;
    logic [19:0] c_rd_dout;

    always #5 clk = ~clk;

    gnrl_dpram #(.DP(DP), .AW(32), .DW(32), .MW(4), .ASH(2), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .init_done(a_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_wem(wr_wem), .wr_rdy(a_wr_rdy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(a_rd_rdy),
        .rd_vld(a_rd_vld), .rd_dout(a_rd_dout), .rd_err(a_rd_err)
    );

    gnrl_dpram #(.DP(DP), .AW(32), .DW(32), .MW(4), .ASH(2), .RD_LAT(2)) u_b (
        .clk(clk), .rst(rst), .init_done(b_init_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_wem(wr_wem), .wr_rdy(b_wr_rdy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(b_rd_rdy),
        .rd_vld(b_rd_vld), .rd_dout(b_rd_dout), .rd_err(b_rd_err)
    );

    gnrl_dpram #(.DP(DP), .AW(32), .DW(20), .MW(3), .ASH(2), .RD_LAT(1)) u_c (
        .clk(clk), .rst(rst), .init_done(c_init_done),
        .wr_req(c_wr_req), .wr_addr(c_wr_addr), .wr_din(c_wr_din), .wr_wem(c_wr_wem), .wr_rdy(c_wr_rdy),
        .rd_req(c_rd_req), .rd_addr(c_rd_addr), .rd_rdy(c_rd_rdy),
        .rd_vld(c_rd_vld), .rd_dout(c_rd_dout), .rd_err(c_rd_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rd_t;

    logic [31:0] mmem [DP];
    rd_t         qa[$], qb[$];
    logic [31:0] last_a, last_b;
    int          since = 0;
    int          cyc = 0;

    typedef struct {
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  wem;
        logic        rd;
        logic [31:0] ra;
        logic [31:0] xd;
        logic        xe;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] wem);
        logic [31:0] w;
        w = old;
        for (int l = 0; l < 4; l++) begin
            if (wem[l]) w[l*8 +: 8] = din[l*8 +: 8];
        end
        return w;
    endfunction

    task automatic model_clear();
        since = 0;
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        for (int k = 0; k < DP; k++) mmem[k] = '0;
    endtask

    // One clock: update model from current inputs, clock, then compare outputs
    task automatic step();
        bit          run_pre, ev;
        logic        ee;
        logic [31:0] d;
        int          ri, wi;
        if (rst) begin
            model_clear();
        end else begin
            run_pre = (since >= DP + 1);
            ri = int'(rd_addr >> 2);
            wi = int'(wr_addr >> 2);
            if (run_pre && rd_req) begin
                if (ri >= DP) begin
                    qa.push_back('{cyc + 1, 32'h0, 1'b1});
                    qb.push_back('{cyc + 2, 32'h0, 1'b1});
                end else begin
                    d = mmem[ri];
                    if (FWD && wr_req && wi == ri) d = merge(d, wr_din, wr_wem);
                    qa.push_back('{cyc + 1, d, 1'b0});
                    qb.push_back('{cyc + 2, d, 1'b0});
                end
            end
            if (run_pre && wr_req && wi < DP) mmem[wi] = merge(mmem[wi], wr_din, wr_wem);
            since++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("ready_a", {29'h0, a_init_done, a_wr_rdy, a_rd_rdy}, {29'h0, {3{since >= DP + 1}}});
        chk("ready_b", {29'h0, b_init_done, b_wr_rdy, b_rd_rdy}, {29'h0, {3{since >= DP + 1}}});
        chk("init_c", {31'h0, c_init_done}, {31'h0, since >= DP + 1});
        ev = 1'b0; ee = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ev = 1'b1; ee = qa[0].e; last_a = qa[0].d; void'(qa.pop_front());
        end
        chk("vld_a", {31'h0, a_rd_vld}, {31'h0, ev});
        chk("err_a", {31'h0, a_rd_err}, {31'h0, ee});
        chk("dout_a", a_rd_dout, last_a);
        ev = 1'b0; ee = 1'b0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            ev = 1'b1; ee = qb[0].e; last_b = qb[0].d; void'(qb.pop_front());
        end
        chk("vld_b", {31'h0, b_rd_vld}, {31'h0, ev});
        chk("err_b", {31'h0, b_rd_err}, {31'h0, ee});
        chk("dout_b", b_rd_dout, last_b);
    endtask

    task automatic idle();
        wr_req = 1'b0; rd_req = 1'b0; wr_wem = '0;
        c_wr_req = 1'b0; c_rd_req = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_vld", {30'h0, a_rd_vld, b_rd_vld}, 32'h0);
        chk("rst_dout_a", a_rd_dout, 32'h0);
        chk("rst_dout_b", b_rd_dout, 32'h0);
        chk("rst_ready", {26'h0, a_init_done, a_wr_rdy, a_rd_rdy, b_init_done, c_init_done, c_rd_rdy}, 32'h0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < DP + 1; k++) step();
    endtask

    task automatic read_all();
        for (int k = 0; k < DP; k++) begin
            rd_req = 1'b1;
            rd_addr = k * 4;
            step();
        end
        idle();
        step();
        step();
    endtask

    task automatic c_op(input logic [19:0] din, input logic [2:0] wem, input logic [19:0] exp);
        c_wr_req = 1'b1; c_wr_addr = 32'h0; c_wr_din = din; c_wr_wem = wem;
        step();
        c_wr_req = 1'b0; c_rd_req = 1'b1; c_rd_addr = 32'h0;
        step();
        c_rd_req = 1'b0;
        chk("c_vld", {31'h0, c_rd_vld}, 32'h1);
        chk("c_err", {31'h0, c_rd_err}, 32'h0);
        chk("c_dout", {12'h0, c_rd_dout}, {12'h0, exp});
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,  32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0, 32'h0,  32'h0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h10, 32'hDEADBEAA, 1'b0};
        tbl[3]  = '{1'b1, 32'h20, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0,  32'h0, 1'b0};
        tbl[4]  = '{1'b1, 32'h20, 32'h11223344, 4'b0011, 1'b1, 32'h20,
                    FWD ? 32'hFFFF3344 : 32'hFFFFFFFF, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h20, 32'hFFFF3344, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h40, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 32'h40, 32'h12345678, 4'b1111, 1'b0, 32'h0,  32'h0, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h0,  32'h0, 1'b0};
        tbl[9]  = '{1'b1, 32'h14, 32'hCAFEF00D, 4'b0000, 1'b1, 32'h14, 32'h0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h14, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 32'h3C, 32'hA5A5A5A5, 4'b1111, 1'b1, 32'h10, 32'hDEADBEAA, 1'b0};
        tbl[12] = '{1'b0, 32'h0,  32'h0,        4'b0000, 1'b1, 32'h3C, 32'hA5A5A5A5, 1'b0};

        #2;
        do_reset();
        read_all();

        for (int i = 0; i < 13; i++) begin
            wr_req = tbl[i].wr; wr_addr = tbl[i].wa; wr_din = tbl[i].wd; wr_wem = tbl[i].wem;
            rd_req = tbl[i].rd; rd_addr = tbl[i].ra;
            step();
            if (tbl[i].rd) begin
                chk($sformatf("tbl%0d_dout", i), a_rd_dout, tbl[i].xd);
                chk($sformatf("tbl%0d_err", i), {31'h0, a_rd_err}, {31'h0, tbl[i].xe});
            end
        end
        idle();
        step();
        read_all();

        c_op(20'hABCDE, 3'b100, 20'hA0000);
        c_op(20'h12345, 3'b001, 20'hA0045);
        c_op(20'hFFFFF, 3'b010, 20'hAFF45);
        step();
        chk("c_idle_vld", {31'h0, c_rd_vld}, 32'h0);
        chk("c_hold", {12'h0, c_rd_dout}, 32'hAFF45);

        for (int i = 0; i < 400; i++) begin
            wr_req = 1'($urandom);
            wr_addr = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
            wr_din = $urandom;
            wr_wem = 4'($urandom);
            rd_req = 1'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr
                    : (($urandom_range(0, 17) << 2) | $urandom_range(0, 3));
            step();
        end
        idle();
        step();
        step();

        for (int k = 0; k < 4; k++) begin
            rd_req = 1'b1;
            rd_addr = k * 4;
            step();
        end
        do_reset();
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
